// File: rtl/lcd_pkg.sv
// Shared HD44780 definitions: write-cycle FSM states, default bus timing and
// the command bytes used by the sequencer.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_EN_HIGH = 3'd2,
        ST_HOLD    = 3'd3,
        ST_DONE    = 3'd4
    } lcd_state_e;

    // Default timing in 50 MHz clock cycles
    localparam int LCD_SETUP_CYC = 4;
    localparam int LCD_EN_CYC    = 16;
    localparam int LCD_HOLD_CYC  = 4;

    localparam logic [7:0] LCD_CMD_FUNC_SET   = 8'h38;
    localparam logic [7:0] LCD_CMD_DISP_ON    = 8'h0C;
    localparam logic [7:0] LCD_CMD_CLEAR      = 8'h01;
    localparam logic [7:0] LCD_CMD_ENTRY_MODE = 8'h06;
    localparam logic [7:0] LCD_CMD_LINE1      = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE2      = 8'hC0;

endpackage

// File: rtl/lcd_bus_driver.sv
// HD44780 write-cycle generator: latches one 9-bit item per start and drives
// RS/DATA setup, EN pulse and hold timing, then pulses done for one cycle.
module lcd_bus_driver
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC = LCD_SETUP_CYC,
    parameter int EN_CYC    = LCD_EN_CYC,
    parameter int HOLD_CYC  = LCD_HOLD_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       rs_in,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_on
);

    localparam int MAX_CYC = (SETUP_CYC > EN_CYC) ?
                             ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                             ((EN_CYC > HOLD_CYC) ? EN_CYC : HOLD_CYC);
    localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LD    = CW'(EN_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

    lcd_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    data_q, data_d;
    logic          rs_q, rs_d;
    logic          en_q, en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          on_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rs_d    = rs_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE accepts a new item directly so back-to-back writes skip IDLE
                if (start) begin
                    data_d  = data_in;
                    rs_d    = rs_in;
                    cnt_d   = SETUP_LD;
                    state_d = ST_SETUP;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = EN_LD;
                    state_d = ST_EN_HIGH;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_EN_HIGH: begin
                if (cnt_q == '0) begin
                    cnt_d   = HOLD_LD;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        // Strobes come from the next state so the flops line up with state_q
        en_d   = (state_d == ST_EN_HIGH);
        busy_d = (state_d == ST_SETUP) || (state_d == ST_EN_HIGH) || (state_d == ST_HOLD);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            on_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            on_q    <= 1'b1;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign lcd_data = data_q;
    assign lcd_rs   = rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_en   = en_q;
    assign lcd_on   = on_q;

endmodule
